// File: rtl/tc_pl_crc_pkg.sv
// Shared constants and helpers for the PL capture CRC-32 engine.
// Combinational helpers only; no state lives here.
// Byte-serial CRC step, 32-bit reflection and eop keep-mask decoding.
package tc_pl_crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  // Widest keep mask supported (DATA_W = 512).
  localparam int KEEP_MAX_W = 64;

  typedef struct packed {
    logic [6:0] cnt;   // leading contiguous ones from bit 0
    logic       viol;  // a one exists above the first zero
  } keep_info_t;

  // One byte through a normal-form (MSB-shifting) CRC register. With reflect
  // set, the byte is fed bit 0 first, so the register stays in normal form
  // and only the final value needs reversing.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  dbyte,
                                             input logic [31:0] poly,
                                             input logic        reflect);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ (reflect ? dbyte[i] : dbyte[7-i]);
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Narrower masks are zero-extended by the caller, which cannot create a
  // violation because the extension sits above the real mask.
  function automatic keep_info_t keep_count(input logic [KEEP_MAX_W-1:0] keep);
    keep_info_t r;
    logic       gap;
    r   = '0;
    gap = 1'b0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (keep[i]) begin
        if (gap) r.viol = 1'b1;
        else     r.cnt  = r.cnt + 7'd1;
      end else begin
        gap = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_pl_crc32_fold.sv
// Folds one data beat into a running CRC, exposing every per-byte partial.
// Purely combinational, zero latency.
// No flow control; the caller selects the partial matching the beat's byte count.
module tc_pl_crc32_fold
  import tc_pl_crc_pkg::*;
#(
  parameter int          DATA_W  = 64,
  parameter logic [31:0] POLY    = CRC32_POLY,
  parameter bit          REFLECT = 1'b1
) (
  input  logic [31:0]                  crc_in,
  input  logic [DATA_W-1:0]            data,
  output logic [DATA_W/8-1:0][31:0]    crc_part
);

  localparam int NB = DATA_W / 8;

  logic [31:0] chain;

  // Byte 0 first; crc_part[k] is the CRC after bytes 0..k.
  always_comb begin
    crc_part = '0;
    chain    = crc_in;
    for (int k = 0; k < NB; k++) begin
      chain       = crc32_byte(chain, data[8*k +: 8], POLY, REFLECT);
      crc_part[k] = chain;
    end
  end

endmodule

// File: rtl/tc_pl_cap_crc32_stream.sv
// Streaming CRC-32 over framed beats with sop/eop and an eop byte mask.
// Result, length and error flag register one cycle after the eop beat.
// Accepts a beat every cycle; there is no backpressure.
module tc_pl_cap_crc32_stream
  import tc_pl_crc_pkg::*;
#(
  parameter int          DATA_W  = 64,
  parameter logic [31:0] POLY    = CRC32_POLY,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOR_OUT = CRC32_XOROUT,
  parameter bit          REFLECT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                crc_en,
  input  logic [DATA_W-1:0]   crc_data,
  input  logic                crc_data_valid,
  input  logic                crc_sop,
  input  logic                crc_eop,
  input  logic [DATA_W/8-1:0] crc_keep,
  output logic [31:0]         crc32,
  output logic                crc32_valid,
  output logic [15:0]         crc_len,
  output logic                crc_busy,
  output logic                crc_err
);

  localparam int         NB   = DATA_W / 8;
  localparam logic [6:0] NB_L = 7'(NB);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] crc32_q, crc32_d;
  logic        crc32_valid_q, crc32_valid_d;
  logic [15:0] crc_len_q, crc_len_d;
  logic        crc_err_q, crc_err_d;

  logic [KEEP_MAX_W-1:0] keep_ext;
  keep_info_t            kinfo;
  logic [6:0]            nbytes;
  logic                  restart;
  logic [31:0]           base_crc;
  logic [15:0]           base_cnt;
  logic [NB-1:0][31:0]   crc_part;
  logic [31:0]           folded;
  logic [16:0]           cnt_sum;
  logic [15:0]           new_cnt;

  tc_pl_crc32_fold #(
    .DATA_W  (DATA_W),
    .POLY    (POLY),
    .REFLECT (REFLECT)
  ) u_fold (
    .crc_in   (base_crc),
    .data     (crc_data),
    .crc_part (crc_part)
  );

  // Beat datapath: pick the starting CRC/count, select the partial for the byte count.
  always_comb begin
    keep_ext           = '0;
    keep_ext[NB-1:0]   = crc_keep;
    kinfo              = keep_count(keep_ext);
    nbytes             = crc_eop ? kinfo.cnt : NB_L;
    restart            = (state_q == ST_IDLE) || crc_sop;
    base_crc           = restart ? INIT : crc_q;
    base_cnt           = restart ? 16'd0 : cnt_q;
    folded             = base_crc;
    for (int k = 1; k <= NB; k++) begin
      if (nbytes == 7'(k)) folded = crc_part[k-1];
    end
    cnt_sum            = {1'b0, base_cnt} + {10'd0, nbytes};
    new_cnt            = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Frame state machine and result capture.
  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q;
    crc32_d       = crc32_q;
    crc_len_d     = crc_len_q;
    crc32_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    if (!crc_en) begin
      state_d = ST_IDLE;
      crc_d   = INIT;
      cnt_d   = '0;
    end else if (crc_data_valid) begin
      if (state_q == ST_IDLE && !crc_sop) begin
        crc_err_d = 1'b1;
      end else begin
        // sop while accumulating abandons the open frame.
        crc_err_d = (state_q == ST_ACC) && crc_sop;
        if (crc_eop) begin
          crc32_d       = (REFLECT ? reflect32(folded) : folded) ^ XOR_OUT;
          crc_len_d     = new_cnt;
          crc32_valid_d = 1'b1;
          crc_err_d     = crc_err_d | kinfo.viol;
          state_d       = ST_IDLE;
          crc_d         = INIT;
          cnt_d         = '0;
        end else begin
          state_d = ST_ACC;
          crc_d   = folded;
          cnt_d   = new_cnt;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      crc_q         <= INIT;
      cnt_q         <= '0;
      crc32_q       <= '0;
      crc32_valid_q <= 1'b0;
      crc_len_q     <= '0;
      crc_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      cnt_q         <= cnt_d;
      crc32_q       <= crc32_d;
      crc32_valid_q <= crc32_valid_d;
      crc_len_q     <= crc_len_d;
      crc_err_q     <= crc_err_d;
    end
  end

  assign crc32       = crc32_q;
  assign crc32_valid = crc32_valid_q;
  assign crc_len     = crc_len_q;
  assign crc_busy    = (state_q == ST_ACC);
  assign crc_err     = crc_err_q;

endmodule

// File: tb/tb_tc_pl_cap_crc32_stream.sv
// Bench for the streaming CRC-32 engine: directed cases plus random framing.
// Two instances share the stimulus: Ethernet defaults and an MPEG-2 variant.
// Expected values come from a frame-level byte-queue model.
module tb_tc_pl_cap_crc32_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        crc_en;
  logic [63:0] crc_data;
  logic        crc_data_valid;
  logic        crc_sop;
  logic        crc_eop;
  logic [7:0]  crc_keep;

  logic [31:0] crc32_e,  crc32_m;
  logic        valid_e,  valid_m;
  logic [15:0] len_e,    len_m;
  logic        busy_e,   busy_m;
  logic        err_e,    err_m;

  always #5 clk = ~clk;

  tc_pl_cap_crc32_stream #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .crc_en(crc_en), .crc_data(crc_data),
    .crc_data_valid(crc_data_valid), .crc_sop(crc_sop), .crc_eop(crc_eop),
    .crc_keep(crc_keep), .crc32(crc32_e), .crc32_valid(valid_e),
    .crc_len(len_e), .crc_busy(busy_e), .crc_err(err_e)
  );

  tc_pl_cap_crc32_stream #(.DATA_W(64), .XOR_OUT(32'h0), .REFLECT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .crc_en(crc_en), .crc_data(crc_data),
    .crc_data_valid(crc_data_valid), .crc_sop(crc_sop), .crc_eop(crc_eop),
    .crc_keep(crc_keep), .crc32(crc32_m), .crc32_valid(valid_m),
    .crc_len(len_m), .crc_busy(busy_m), .crc_err(err_m)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the bytes of the open frame, plus the last results.
  logic [7:0]  q[$];
  bit          m_in_frame;
  logic [31:0] m_crc_e, m_crc_m;
  logic [15:0] m_len;
  bit          m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Ethernet CRC-32 the textbook way: reflected polynomial, right shifts.
  function automatic logic [31:0] ref_eth();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // MPEG-2 CRC-32: MSB-first, no reflection, no output xor.
  function automatic logic [31:0] ref_mpeg();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {q[i], 24'd0};
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic model_reset();
    q.delete();
    m_in_frame = 0;
    m_crc_e = '0; m_crc_m = '0; m_len = '0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step();
    int  n;
    bit  viol;
    m_valid = 0;
    m_err   = 0;
    if (!crc_en) begin
      m_in_frame = 0;
      q.delete();
    end else if (crc_data_valid) begin
      if (!m_in_frame && !crc_sop) begin
        m_err = 1;
      end else begin
        if (m_in_frame && crc_sop) m_err = 1;
        if (crc_sop) q.delete();
        n    = 8;
        viol = 0;
        if (crc_eop) begin
          n = 0;
          while (n < 8 && crc_keep[n]) n++;
          viol = ((crc_keep >> n) != 8'd0);
        end
        for (int i = 0; i < n; i++) q.push_back(crc_data[8*i +: 8]);
        if (crc_eop) begin
          m_crc_e    = ref_eth();
          m_crc_m    = ref_mpeg();
          m_len      = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
          m_valid    = 1;
          m_err      = m_err | viol;
          m_in_frame = 0;
          q.delete();
        end else begin
          m_in_frame = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("crc32",       crc32_e,            m_crc_e);
    chk("crc32_valid", {31'd0, valid_e},   {31'd0, m_valid});
    chk("crc_len",     {16'd0, len_e},     {16'd0, m_len});
    chk("crc_busy",    {31'd0, busy_e},    {31'd0, m_in_frame});
    chk("crc_err",     {31'd0, err_e},     {31'd0, m_err});
    chk("mpeg_crc32",  crc32_m,            m_crc_m);
    chk("mpeg_valid",  {31'd0, valid_m},   {31'd0, m_valid});
  endtask

  // Drive one cycle of inputs, let the edge sample them, then check.
  task automatic beat(input bit en, input bit v, input bit sop, input bit eop,
                      input logic [63:0] data, input logic [7:0] keep);
    crc_en = en; crc_data_valid = v; crc_sop = sop; crc_eop = eop;
    crc_data = data; crc_keep = keep;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; crc_en = 1'b0; crc_data_valid = 1'b0; crc_sop = 1'b0;
    crc_eop = 1'b0; crc_data = '0; crc_keep = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    beat(1, 0, 0, 0, 64'd0, 8'h00);

    // "123456789", then a back-to-back single-zero-byte frame.
    beat(1, 1, 1, 0, 64'h3837363534333231, 8'hFF);
    beat(1, 1, 0, 1, 64'h39, 8'h01);
    chk("check_eth", crc32_e, 32'hCBF43926);
    chk("check_mpeg", crc32_m, 32'h0376E6E7);
    chk("check_len", {16'd0, len_e}, 32'd9);
    beat(1, 1, 1, 1, 64'h0, 8'h01);
    chk("b2b_zero_byte", crc32_e, 32'hD202EF8D);
    chk("b2b_valid", {31'd0, valid_e}, 32'd1);
    beat(1, 1, 1, 1, 64'h0, 8'h00);
    chk("empty_frame", crc32_e, 32'h00000000);
    chk("empty_len", {16'd0, len_e}, 32'd0);

    // Non-contiguous keep, stray beat in IDLE, sop inside a frame.
    beat(1, 1, 1, 1, 64'h1122334455667788, 8'h05);
    chk("keep05_len", {16'd0, len_e}, 32'd1);
    chk("keep05_err", {31'd0, err_e}, 32'd1);
    beat(1, 1, 0, 0, 64'hDEADBEEF, 8'hFF);
    beat(1, 1, 1, 0, 64'hAAAA, 8'hFF);
    beat(1, 1, 1, 0, 64'h3837363534333231, 8'hFF);
    beat(1, 1, 0, 1, 64'h39, 8'h01);
    chk("restart_eth", crc32_e, 32'hCBF43926);

    // Enable dropped mid-frame, then reset mid-frame.
    beat(1, 1, 1, 0, 64'h0123456789ABCDEF, 8'hFF);
    beat(0, 1, 0, 1, 64'h55, 8'h01);
    chk("en_drop_hold", crc32_e, 32'hCBF43926);
    beat(1, 1, 1, 0, 64'h0123456789ABCDEF, 8'hFF);
    do_reset();

    // Long frame: the length must saturate.
    beat(1, 1, 1, 0, {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 8200; i++) beat(1, 1, 0, 0, {$urandom, $urandom}, 8'hFF);
    beat(1, 1, 0, 1, {$urandom, $urandom}, 8'h0F);
    chk("len_saturate", {16'd0, len_e}, 32'h0000FFFF);

    // Random framing, keep masks, enable drops and the odd reset.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] kp;
      case ($urandom_range(0, 3))
        0:       kp = 8'hFF;
        1:       kp = 8'hFF >> $urandom_range(0, 8);
        default: kp = 8'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else beat($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                {$urandom, $urandom}, kp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
